// File: rtl/tnn_wave_sequencer_pkg.sv
// tnn_seq_pkg: shared types and constants for the TNN wave sequencer.
//   seq_state_t  - sequencer state (IDLE, GRST, RUN, DONE)
//   *_DEF        - default parameter values of the column slice
//   NO_SPIKE     - output-time code reported for an output that never fired
//   timing_ok()  - checks that a wave is long enough to hold the latest
//                  input pulse plus the time-origin cycle
package tnn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GRST = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

  localparam int P_DEF         = 4;
  localparam int Q_DEF         = 4;
  localparam int TRES_DEF      = 3;
  localparam int PULSE_W_DEF   = 8;
  localparam int GAMMA_LEN_DEF = 24;
  localparam int CW_DEF        = $clog2(GAMMA_LEN_DEF);

  localparam logic [CW_DEF-1:0] NO_SPIKE = '1;

  // The latest spike (time 2^TRES-1) starts at cnt 2^TRES and its pulse must
  // end inside the wave.
  function automatic bit timing_ok(input int tres, input int pulse_w,
                                   input int gamma_len);
    return gamma_len >= (1 << tres) + pulse_w + 1;
  endfunction

endpackage

// File: rtl/tnn_wave_sequencer_if.sv
// tnn_wave_sequencer_if: host stream + column-side signals of the sequencer.
//   Sample in : in_valid/in_ready, in_times, in_present, in_learn
//   Column    : grst, input_spikes, learn_en (out), output_spikes (in)
//   Result out: out_valid/out_ready, out_times, out_fired
//   Status    : wave_count, state_dbg
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both 1; the producer holds its payload stable while valid is 1 and
// ready is 0, and valid never depends combinationally on ready.
// modport slave is the sequencer; modport master is the host/column side.
interface tnn_wave_sequencer_if
  import tnn_seq_pkg::*;
#(
  parameter int P    = P_DEF,
  parameter int Q    = Q_DEF,
  parameter int TRES = TRES_DEF,
  parameter int CW   = CW_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [P*TRES-1:0] in_times;
  logic [P-1:0]      in_present;
  logic              in_learn;
  logic              grst;
  logic [P-1:0]      input_spikes;
  logic              learn_en;
  logic [Q-1:0]      output_spikes;
  logic              out_valid;
  logic              out_ready;
  logic [Q*CW-1:0]   out_times;
  logic [Q-1:0]      out_fired;
  logic [15:0]       wave_count;
  seq_state_t        state_dbg;

  modport slave (
    input  in_valid, in_times, in_present, in_learn, output_spikes, out_ready,
    output in_ready, grst, input_spikes, learn_en, out_valid, out_times,
           out_fired, wave_count, state_dbg
  );

  modport master (
    output in_valid, in_times, in_present, in_learn, output_spikes, out_ready,
    input  in_ready, grst, input_spikes, learn_en, out_valid, out_times,
           out_fired, wave_count, state_dbg
  );

endinterface

// File: rtl/tnn_wave_sequencer_capture.sv
// first_spike_capture: first-spike time register for one LI output.
//   clk, rst    - clock, async active-high reset
//   clear       - start of wave: forget previous result
//   sample      - wave counter is in the RUN window
//   spike       - LI output pulse
//   cnt         - wave counter (time origin at cnt = 1)
//   fired       - output spiked during this wave
//   spike_time  - first-spike time, all-ones when not fired
module first_spike_capture
  import tnn_seq_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          sample,
  input  logic          spike,
  input  logic [CW-1:0] cnt,
  output logic          fired,
  output logic [CW-1:0] spike_time
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fired      <= 1'b0;
      spike_time <= '1;
    end else if (clear) begin
      fired      <= 1'b0;
      spike_time <= '1;
    end else if (sample && spike && !fired) begin
      fired <= 1'b1;
      // A spike at cnt 0 precedes the time origin; clamp it to 0.
      spike_time <= (cnt == '0) ? '0 : cnt - CW'(1);
    end
  end

endmodule

// File: rtl/tnn_wave_sequencer.sv
// tnn_wave_sequencer: runs one gamma wave of the TNN column per sample.
//   clk, rst - clock, async active-high reset
//   bus      - tnn_wave_sequencer_if.slave (sample in, column I/O, result out)
// Flow: IDLE accepts a sample -> GRST pulses grst for one cycle -> RUN counts
// cnt 0..GAMMA_LEN-1, emitting input pulses and capturing first output
// spikes -> DONE presents the result until out_ready.
module tnn_wave_sequencer
  import tnn_seq_pkg::*;
#(
  parameter int P         = P_DEF,
  parameter int Q         = Q_DEF,
  parameter int TRES      = TRES_DEF,
  parameter int PULSE_W   = PULSE_W_DEF,
  parameter int GAMMA_LEN = GAMMA_LEN_DEF,
  parameter int CW        = $clog2(GAMMA_LEN)
) (
  input logic                 clk,
  input logic                 rst,
  tnn_wave_sequencer_if.slave bus
);

  if (!timing_ok(TRES, PULSE_W, GAMMA_LEN)) begin : g_bad_timing
    $error("GAMMA_LEN too short for TRES and PULSE_W");
  end

  localparam logic [CW-1:0] LAST_CNT = CW'(GAMMA_LEN - 1);

  seq_state_t        state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [P*TRES-1:0] times_q;
  logic [P-1:0]      present_q;
  logic              learn_q;
  logic              in_ready_q;
  logic [P-1:0]      spikes_q, spikes_n;
  logic [15:0]       wave_count_q;
  logic              accept, finish;
  logic [Q-1:0]      fired;
  logic [Q*CW-1:0]   times_w;
  int                t_i;

  // Next state / counter.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid && in_ready_q) begin
        accept  = 1'b1;
        state_n = GRST;
      end
      GRST: begin
        cnt_n   = '0;
        state_n = RUN;
      end
      RUN: begin
        if (cnt_q == LAST_CNT) state_n = DONE;
        else                   cnt_n   = cnt_q + CW'(1);
      end
      DONE: if (bus.out_ready) begin
        finish  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Pulses are decoded from the next counter value so the registered output
  // lines up with cnt_q in the same cycle; outside RUN they are forced low.
  always_comb begin
    spikes_n = '0;
    t_i      = 0;
    if (state_n == RUN) begin
      for (int i = 0; i < P; i++) begin
        t_i = int'(times_q[i*TRES +: TRES]);
        spikes_n[i] = present_q[i] && (int'(cnt_n) >= t_i + 1)
                      && (int'(cnt_n) <= t_i + PULSE_W);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      times_q      <= '0;
      present_q    <= '0;
      learn_q      <= 1'b0;
      in_ready_q   <= 1'b0;
      spikes_q     <= '0;
      wave_count_q <= '0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      in_ready_q <= (state_n == IDLE);
      spikes_q   <= spikes_n;
      if (accept) begin
        times_q   <= bus.in_times;
        present_q <= bus.in_present;
        learn_q   <= bus.in_learn;
      end
      if (finish) wave_count_q <= wave_count_q + 16'd1;
    end
  end

  for (genvar j = 0; j < Q; j++) begin : g_cap
    first_spike_capture #(.CW(CW)) u_cap (
      .clk       (clk),
      .rst       (rst),
      .clear     (state_q == GRST),
      .sample    (state_q == RUN),
      .spike     (bus.output_spikes[j]),
      .cnt       (cnt_q),
      .fired     (fired[j]),
      .spike_time(times_w[j*CW +: CW])
    );
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.grst         = (state_q == GRST);
  assign bus.input_spikes = spikes_q;
  assign bus.learn_en     = learn_q && (state_q != IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_times    = times_w;
  assign bus.out_fired    = fired;
  assign bus.wave_count   = wave_count_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_tnn_wave_sequencer.sv
module tb_tnn_wave_sequencer;
  import tnn_seq_pkg::*;

  localparam int P         = 4;
  localparam int Q         = 4;
  localparam int TRES      = 3;
  localparam int PULSE_W   = 8;
  localparam int GAMMA_LEN = 24;
  localparam int CW        = $clog2(GAMMA_LEN);
  localparam int TW        = P * TRES;
  localparam int W         = Q * CW + Q;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tnn_wave_sequencer_if #(.P(P), .Q(Q), .TRES(TRES), .CW(CW)) bus ();

  tnn_wave_sequencer #(
    .P(P), .Q(Q), .TRES(TRES), .PULSE_W(PULSE_W), .GAMMA_LEN(GAMMA_LEN), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_wave  = 0;
  logic [W-1:0] exp_q[$];
  logic [Q-1:0] pat [GAMMA_LEN];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Spike time t is seen at cnt t+1 and lasts PULSE_W cycles.
  function automatic logic [P-1:0] model_pulses(input logic [TW-1:0] t,
                                                input logic [P-1:0] pr,
                                                input int c);
    logic [P-1:0] r;
    int ti;
    r = '0;
    for (int i = 0; i < P; i++) begin
      ti = int'(t[i*TRES +: TRES]);
      if (pr[i] && (c - (ti + 1)) >= 0 && (c - (ti + 1)) < PULSE_W) r[i] = 1'b1;
    end
    return r;
  endfunction

  // First high cycle of each output in pat; time relative to origin cnt 1.
  function automatic logic [W-1:0] model_result();
    logic [Q-1:0]    f;
    logic [Q*CW-1:0] tm;
    f  = '0;
    tm = '1;
    for (int j = 0; j < Q; j++) begin
      for (int c = GAMMA_LEN - 1; c >= 0; c--) begin
        if (pat[c][j]) begin
          f[j] = 1'b1;
          tm[j*CW +: CW] = (c == 0) ? CW'(0) : CW'(c - 1);
        end
      end
    end
    return {tm, f};
  endfunction

  // ---------------- driver ----------------
  task automatic clear_pat();
    for (int c = 0; c < GAMMA_LEN; c++) pat[c] = '0;
  endtask

  // Entered and left on a falling edge.
  task automatic run_wave(input logic [TW-1:0] t, input logic [P-1:0] pr,
                          input logic ln, input int ready_delay);
    logic [W-1:0] exp;
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.in_valid   = 1'b1;
    bus.in_times   = t;
    bus.in_present = pr;
    bus.in_learn   = ln;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("grst_pulse", 32'(bus.grst), 32'd1);
    check("state_grst", 32'(bus.state_dbg), 32'(GRST));
    check("in_ready_busy", 32'(bus.in_ready), 32'd0);
    check("learn_grst", 32'(bus.learn_en), 32'(ln));
    @(negedge clk);
    for (int c = 0; c < GAMMA_LEN; c++) begin
      check($sformatf("pulse_c%0d", c), 32'(bus.input_spikes), 32'(model_pulses(t, pr, c)));
      check("grst_run", 32'(bus.grst), 32'd0);
      check("learn_run", 32'(bus.learn_en), 32'(ln));
      bus.output_spikes = pat[c];
      @(negedge clk);
    end
    bus.output_spikes = '0;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd0, 32'd1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("out_fired", 32'(bus.out_fired), 32'(exp[Q-1:0]));
    check("out_times", 32'(bus.out_times), 32'(exp[W-1:Q]));
    check("pulse_done", 32'(bus.input_spikes), 32'd0);
    for (int d = 0; d < ready_delay; d++) begin
      bus.out_ready  = 1'b0;
      bus.in_valid   = 1'b1;            // must be ignored while DONE
      bus.in_times   = TW'($urandom);
      bus.in_present = P'($urandom);
      @(negedge clk);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_grst", 32'(bus.grst), 32'd0);
      check("bp_fired", 32'(bus.out_fired), 32'(exp[Q-1:0]));
      check("bp_times", 32'(bus.out_times), 32'(exp[W-1:Q]));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_wave = (exp_wave + 1) % 65536;
    check("valid_drop", 32'(bus.out_valid), 32'd0);
    check("in_ready_back", 32'(bus.in_ready), 32'd1);
    check("wave_count", 32'(bus.wave_count), 32'(exp_wave));
    check("learn_idle", 32'(bus.learn_en), 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [TW-1:0]   times;
    logic [P-1:0]    present;
    logic            learn;
    int              e0_cnt, e1_cnt, e2_cnt;
    logic [Q-1:0]    e0_mask, e1_mask, e2_mask;
    int              ready_delay;
    logic [Q-1:0]    exp_fired;
    logic [Q*CW-1:0] exp_times;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [TW-1:0] rt;
    logic [P-1:0]  rp;
    logic [2:0]    learn_seq;
    int grst_seen, last_grst, cyc, start_wave;

    // pulse timing + capture with repeated high on output 0
    vecs[0] = '{times: {3'd2, 3'd7, 3'd3, 3'd0}, present: 4'b1111, learn: 1'b1,
                e0_cnt: 12, e0_mask: 4'b0100, e1_cnt: 15, e1_mask: 4'b0001,
                e2_cnt: 16, e2_mask: 4'b0001, ready_delay: 0,
                exp_fired: 4'b0101, exp_times: {5'd31, 5'd11, 5'd31, 5'd14}};
    // absent inputs, spike in last RUN cycle, backpressure
    vecs[1] = '{times: {3'd5, 3'd1, 3'd4, 3'd6}, present: 4'b0110, learn: 1'b0,
                e0_cnt: 23, e0_mask: 4'b0010, e1_cnt: 0, e1_mask: 4'b0000,
                e2_cnt: 0, e2_mask: 4'b0000, ready_delay: 10,
                exp_fired: 4'b0010, exp_times: {5'd31, 5'd31, 5'd22, 5'd31}};
    // simultaneous spikes at cnt 0 clamp to time 0
    vecs[2] = '{times: {3'd7, 3'd7, 3'd7, 3'd7}, present: 4'b1001, learn: 1'b1,
                e0_cnt: 0, e0_mask: 4'b1111, e1_cnt: 3, e1_mask: 4'b0010,
                e2_cnt: 0, e2_mask: 4'b0000, ready_delay: 1,
                exp_fired: 4'b1111, exp_times: {5'd0, 5'd0, 5'd0, 5'd0}};
    // cnt 1 is time 0; later highs ignored
    vecs[3] = '{times: {3'd0, 3'd1, 3'd2, 3'd3}, present: 4'b1010, learn: 1'b0,
                e0_cnt: 1, e0_mask: 4'b1000, e1_cnt: 5, e1_mask: 4'b1000,
                e2_cnt: 9, e2_mask: 4'b0100, ready_delay: 2,
                exp_fired: 4'b1100, exp_times: {5'd0, 5'd8, 5'd31, 5'd31}};

    bus.in_valid = 1'b0; bus.in_times = '0; bus.in_present = '0;
    bus.in_learn = 1'b0; bus.output_spikes = '0; bus.out_ready = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_grst", 32'(bus.grst), 32'd0);
    check("rst_pulses", 32'(bus.input_spikes), 32'd0);
    check("rst_learn", 32'(bus.learn_en), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fired", 32'(bus.out_fired), 32'd0);
    check("rst_times", 32'(bus.out_times), 32'h000F_FFFF);
    check("rst_wave_count", 32'(bus.wave_count), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(IDLE));
    rst = 1'b0;
    check("in_ready_in_rst_cycle", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // ---- table-driven waves ----
    for (int v = 0; v < 4; v++) begin
      clear_pat();
      pat[vecs[v].e0_cnt] |= vecs[v].e0_mask;
      pat[vecs[v].e1_cnt] |= vecs[v].e1_mask;
      pat[vecs[v].e2_cnt] |= vecs[v].e2_mask;
      exp_q.push_back({vecs[v].exp_times, vecs[v].exp_fired});
      run_wave(vecs[v].times, vecs[v].present, vecs[v].learn, vecs[v].ready_delay);
    end

    // ---- back-to-back: in_valid held, out_ready held ----
    learn_seq  = 3'b101;
    start_wave = exp_wave;
    grst_seen  = 0;
    last_grst  = 0;
    cyc        = 0;
    bus.out_ready  = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_times   = TW'($urandom);
    bus.in_present = P'($urandom);
    bus.in_learn   = learn_seq[0];
    while (grst_seen < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.grst) begin
        check("b2b_learn", 32'(bus.learn_en), 32'(learn_seq[grst_seen]));
        if (grst_seen > 0) check("b2b_spacing", 32'(cyc - last_grst), 32'(GAMMA_LEN + 3));
        last_grst = cyc;
        grst_seen++;
        if (grst_seen < 3) begin
          bus.in_learn   = learn_seq[grst_seen];
          bus.in_times   = TW'($urandom);
          bus.in_present = P'($urandom);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    check("b2b_grst_count", 32'(grst_seen), 32'd3);
    repeat (GAMMA_LEN + 3) @(negedge clk);
    bus.out_ready = 1'b0;
    exp_wave = (start_wave + 3) % 65536;
    check("b2b_wave_count", 32'(bus.wave_count), 32'(exp_wave));
    check("b2b_idle_ready", 32'(bus.in_ready), 32'd1);
    check("b2b_idle_valid", 32'(bus.out_valid), 32'd0);

    // ---- randomized waves against the model ----
    for (int n = 0; n < 8; n++) begin
      rt = TW'($urandom);
      rp = P'($urandom);
      for (int c = 0; c < GAMMA_LEN; c++)
        for (int j = 0; j < Q; j++)
          pat[c][j] = ($urandom_range(0, 9) == 0);
      exp_q.push_back(model_result());
      run_wave(rt, rp, 1'($urandom), int'($urandom_range(0, 3)));
    end

    // ---- reset mid-RUN with pulses active ----
    clear_pat();
    bus.in_valid   = 1'b1;
    bus.in_times   = '0;
    bus.in_present = 4'b1111;
    bus.in_learn   = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    repeat (5) @(negedge clk);
    check("mid_pulses_on", 32'(bus.input_spikes), 32'(model_pulses('0, 4'b1111, 5)));
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pulses", 32'(bus.input_spikes), 32'd0);
    check("mid_rst_grst", 32'(bus.grst), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_learn", 32'(bus.learn_en), 32'd0);
    check("mid_rst_wave_count", 32'(bus.wave_count), 32'd0);
    exp_wave = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_no_result", 32'(bus.out_valid), 32'd0);

    // one wave after reset
    for (int c = 0; c < GAMMA_LEN; c++)
      for (int j = 0; j < Q; j++)
        pat[c][j] = ($urandom_range(0, 7) == 0);
    exp_q.push_back(model_result());
    run_wave(TW'($urandom), P'($urandom), 1'b1, 0);

    // ---- final report ----
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
